// File: rtl/sr_sched_pkg.sv
// Shared state encoding and operation constants for the SR flag scheduler.
package sr_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SETTLE = 2'd2,
      CHECK  = 2'd3
   } sched_state_e;

   localparam logic OP_SET   = 1'b1;
   localparam logic OP_CLEAR = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after i_ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int unsigned N    = 4,
   parameter int unsigned ID_W = $clog2(N)
) (
   input  logic [N-1:0]    i_req,
   input  logic [ID_W-1:0] i_ptr,
   input  logic            i_enable,
   output logic [N-1:0]    o_grant,
   output logic [ID_W-1:0] o_grant_id
);

   logic            w_found;
   logic [ID_W-1:0] w_j;

   always_comb begin
      o_grant    = '0;
      o_grant_id = '0;
      w_found    = 1'b0;
      w_j        = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_j = ID_W'((32'(i_ptr) + k) % N);
         if (i_enable && !w_found && i_req[w_j]) begin
            o_grant[w_j] = 1'b1;
            o_grant_id   = w_j;
            w_found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sr_flag_scheduler.sv
// Serialises set/clear requests onto an SR flop bank, one S or R pulse at a time,
// and confirms each operation by reading Q back.
module sr_flag_scheduler
   import sr_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned NUM_FLAGS = 8,
   parameter int unsigned IDX_W     = $clog2(NUM_FLAGS),
   parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ-1:0]       req_op,
   input  logic [NUM_REQ*IDX_W-1:0] req_idx,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_FLAGS-1:0]     sr_s,
   output logic [NUM_FLAGS-1:0]     sr_r,
   input  logic [NUM_FLAGS-1:0]     sr_q,
   output logic                     done,
   output logic [ID_W-1:0]          done_id,
   output logic                     err
);

   localparam logic [IDX_W:0] LP_NUM_FLAGS = (IDX_W + 1)'(NUM_FLAGS);

   sched_state_e r_state, w_state_d;

   logic [ID_W-1:0]      r_ptr;
   logic [ID_W-1:0]      r_id;
   logic                 r_op;
   logic [IDX_W-1:0]     r_idx;
   logic [NUM_FLAGS-1:0] r_sr_s;
   logic [NUM_FLAGS-1:0] r_sr_r;

   logic [NUM_REQ-1:0]   w_grant;
   logic [ID_W-1:0]      w_gid;
   logic                 w_hs;
   logic                 w_sel_op;
   logic [IDX_W-1:0]     w_sel_idx;
   logic [ID_W-1:0]      w_ptr_d;
   logic [NUM_FLAGS-1:0] w_s_d;
   logic [NUM_FLAGS-1:0] w_r_d;
   logic                 w_idx_ok;
   logic                 w_q_bit;

   rr_arbiter #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_arb (
      .i_req      (req_valid),
      .i_ptr      (r_ptr),
      .i_enable   (r_state == IDLE),
      .o_grant    (w_grant),
      .o_grant_id (w_gid)
   );

   assign req_ready = w_grant;
   // The arbiter only grants valid requesters, so any grant is a handshake.
   assign w_hs      = |w_grant;
   assign w_sel_op  = req_op[w_gid];
   assign w_sel_idx = req_idx[w_gid*IDX_W +: IDX_W];
   assign w_ptr_d   = (w_gid == ID_W'(NUM_REQ - 1)) ? '0 : w_gid + 1'b1;

   // S/R pulse is loaded on the accept edge so it is visible for exactly the DRIVE cycle.
   always_comb begin
      w_s_d = '0;
      w_r_d = '0;
      if (w_hs) begin
         for (int unsigned i = 0; i < NUM_FLAGS; i++) begin
            if (w_sel_idx == IDX_W'(i)) begin
               w_s_d[i] = (w_sel_op == OP_SET);
               w_r_d[i] = (w_sel_op == OP_CLEAR);
            end
         end
      end
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         IDLE:    if (w_hs) w_state_d = DRIVE;
         DRIVE:   w_state_d = SETTLE;
         SETTLE:  w_state_d = CHECK;
         CHECK:   w_state_d = IDLE;
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_id    <= '0;
         r_op    <= OP_CLEAR;
         r_idx   <= '0;
         r_sr_s  <= '0;
         r_sr_r  <= '0;
      end else begin
         r_state <= w_state_d;
         r_sr_s  <= w_s_d;
         r_sr_r  <= w_r_d;
         if (w_hs) begin
            r_ptr <= w_ptr_d;
            r_id  <= w_gid;
            r_op  <= w_sel_op;
            r_idx <= w_sel_idx;
         end
      end
   end

   assign sr_s = r_sr_s;
   assign sr_r = r_sr_r;

   // Out-of-range indices are only possible when NUM_FLAGS is not a power of two.
   assign w_idx_ok = ({1'b0, r_idx} < LP_NUM_FLAGS);
   assign w_q_bit  = w_idx_ok ? sr_q[r_idx] : 1'b0;

   assign done    = (r_state == CHECK);
   assign done_id = done ? r_id : '0;
   assign err     = done & (~w_idx_ok | (w_q_bit != r_op));

endmodule
